// File: rtl/ram_param_ctrl_if.sv
// Request/response bundle for ram_param_ctrl: the requester drives the master side,
// and the RAM drives the slave side.
`timescale 1ns/1ps
interface ram_param_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
);
  logic                  cs;
  logic                  rw;
  logic [ADDR_W-1:0]     adrs;
  logic [DATA_W-1:0]     data_in;
  logic [DATA_W/8-1:0]   be;
  logic                  clr;
  logic [DATA_W-1:0]     data_out;
  logic                  rd_valid;
  logic                  ready;
  logic                  init_done;
  logic                  par_err;

  modport master (
    output cs, rw, adrs, data_in, be, clr,
    input  data_out, rd_valid, ready, init_done, par_err
  );

  modport slave (
    input  cs, rw, adrs, data_in, be, clr,
    output data_out, rd_valid, ready, init_done, par_err
  );
endinterface

// File: rtl/ram_param_ctrl.sv
// Parametrised single-port RAM with byte enables, RD_LAT-stage read pipeline and init sequencer.
// Optional per-byte even parity storage is enabled by defining PARITY_EN.
`timescale 1ns/1ps
module ram_param_ctrl #(
  parameter int                 DATA_W   = 32,
  parameter int                 ADDR_W   = 8,
  parameter int                 DEPTH    = 2**ADDR_W,
  parameter int                 RD_LAT   = 1,
  parameter logic [DATA_W-1:0]  INIT_VAL = '0
) (
  input  logic           clk,
  input  logic           rst_n,
  ram_param_ctrl_if.slave bus
);
  localparam int NB = DATA_W/8;
  localparam logic [ADDR_W-1:0] LAST      = ADDR_W'(DEPTH-1);
  localparam logic [ADDR_W:0]   DEPTH_CMP = (ADDR_W+1)'(DEPTH);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                init_done_q;
  logic                we;
  logic [ADDR_W-1:0]   waddr;
  logic [DATA_W-1:0]   wdata;
  logic [NB-1:0]       wbe;
  logic                rd_req;
  logic                in_range;
  logic [DATA_W-1:0]   rd_word;
  logic                rd_perr;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic [RD_LAT-1:0]   pv_q;
  logic [RD_LAT-1:0]   pp_q;
  logic [DATA_W-1:0]   pd_q [RD_LAT];
  logic [DATA_W-1:0]   data_out_q;
  logic                rd_valid_q;
  logic                par_err_q;

  assign in_range = ({1'b0, bus.adrs} < DEPTH_CMP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_q | (state_q == S_INIT && state_d == S_RUN);
    end
  end

  // INIT owns the write port; in RUN a clr pulse pre-empts any request on the same edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we      = 1'b0;
    waddr   = bus.adrs;
    wdata   = bus.data_in;
    wbe     = bus.be;
    rd_req  = 1'b0;
    case (state_q)
      S_INIT: begin
        we    = 1'b1;
        waddr = cnt_q;
        wdata = INIT_VAL;
        wbe   = '1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (bus.clr) begin
          state_d = S_INIT;
          cnt_d   = '0;
        end else if (!bus.cs) begin
          if (bus.rw) we = in_range;
          else        rd_req = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NB; i++)
        if (wbe[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rd_word = in_range ? mem[bus.adrs] : '0;

`ifdef PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];
  logic [NB-1:0] rd_par;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NB; i++)
        if (wbe[i]) par_mem[waddr][i] <= ^wdata[8*i +: 8];
    end
  end

  always_comb begin
    rd_par = '0;
    for (int i = 0; i < NB; i++) rd_par[i] = ^rd_word[8*i +: 8];
  end

  assign rd_perr = in_range && ((rd_par ^ par_mem[bus.adrs]) != '0);
`else
  assign rd_perr = 1'b0;
`endif

  // Stage 0 captures the array at the request edge; outputs register after the last stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv_q       <= '0;
      pp_q       <= '0;
      for (int i = 0; i < RD_LAT; i++) pd_q[i] <= '0;
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
      par_err_q  <= 1'b0;
    end else begin
      pv_q[0] <= rd_req;
      pp_q[0] <= rd_req & rd_perr;
      if (rd_req) pd_q[0] <= rd_word;
      for (int i = 1; i < RD_LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
        pp_q[i] <= pp_q[i-1];
        pd_q[i] <= pd_q[i-1];
      end
      rd_valid_q <= pv_q[RD_LAT-1];
      par_err_q  <= pv_q[RD_LAT-1] & pp_q[RD_LAT-1];
      if (pv_q[RD_LAT-1]) data_out_q <= pd_q[RD_LAT-1];
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.par_err   = par_err_q;
  assign bus.ready     = (state_q == S_RUN);
  assign bus.init_done = init_done_q;
endmodule
